// File: rtl/cla_chunk_add_seq.sv
// Multi-cycle wide add/subtract sequencer: walks a DATA_W-bit operand pair through one
// CHUNK_W-bit carry-lookahead adder, LSB chunk first, registering the inter-chunk carry.
module cla_chunk_add_seq #(
    parameter  int CHUNK_W    = 16,
    parameter  int NUM_CHUNKS = 4,
    localparam int DATA_W     = CHUNK_W * NUM_CHUNKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf,
    output logic              busy
);

    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int NUM_GROUPS = CHUNK_W / 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;      // already inverted for subtraction
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;

    logic [CHUNK_W-1:0]  w_a_chunk;
    logic [CHUNK_W-1:0]  w_b_chunk;
    logic [CHUNK_W-1:0]  w_p;
    logic [CHUNK_W-1:0]  w_g;
    logic [CHUNK_W-1:0]  w_c;
    logic [CHUNK_W-1:0]  w_s;
    logic [NUM_GROUPS:0] w_gc;
    logic                w_last;

    assign w_a_chunk = r_a[int'(r_idx) * CHUNK_W +: CHUNK_W];
    assign w_b_chunk = r_b[int'(r_idx) * CHUNK_W +: CHUNK_W];
    assign w_last    = (r_idx == IDX_W'(NUM_CHUNKS - 1));

    assign w_p     = w_a_chunk ^ w_b_chunk;
    assign w_g     = w_a_chunk & w_b_chunk;
    assign w_gc[0] = r_carry;

    // Each 4-bit group resolves its internal carries in parallel; groups chain via group P/G.
    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
        logic [3:0] w_gp;
        logic [3:0] w_gg;
        logic       w_gcin;

        assign w_gp   = w_p[4*gi +: 4];
        assign w_gg   = w_g[4*gi +: 4];
        assign w_gcin = w_gc[gi];

        assign w_c[4*gi]   = w_gcin;
        assign w_c[4*gi+1] = w_gg[0] | (w_gp[0] & w_gcin);
        assign w_c[4*gi+2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_gcin);
        assign w_c[4*gi+3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                           | (w_gp[2] & w_gp[1] & w_gp[0] & w_gcin);
        assign w_gc[gi+1]  = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                           | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                           | ((&w_gp) & w_gcin);
    end

    assign w_s = w_p ^ w_c;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a      <= a;
                        r_b      <= sub ? ~b : b;
                        r_carry  <= sub ? 1'b1 : cin;
                        r_idx    <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[int'(r_idx) * CHUNK_W +: CHUNK_W] <= w_s;
                    r_carry <= w_gc[NUM_GROUPS];
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        cout      <= w_gc[NUM_GROUPS];
                        ovf       <= (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                                     (w_s[CHUNK_W-1] != r_a[DATA_W-1]);
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_chunk_add_seq.sv
// Scoreboard bench for cla_chunk_add_seq: expected results are queued at accept time and
// compared by a monitor whenever a result handshake is about to happen.
module tb_cla_chunk_add_seq;

    localparam int CHUNK_W    = 16;
    localparam int NUM_CHUNKS = 4;
    localparam int DATA_W     = CHUNK_W * NUM_CHUNKS;
    localparam int LAT        = NUM_CHUNKS;
    // accept edge + NUM_CHUNKS chunk edges + result handshake edge, then in_ready is back
    localparam int PERIOD     = NUM_CHUNKS + 2;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              cout;
        logic              ovf;
    } res_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    res_t exp_q[$];
    res_t mon_e;

    cla_chunk_add_seq #(
        .CHUNK_W   (CHUNK_W),
        .NUM_CHUNKS(NUM_CHUNKS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [DATA_W-1:0] a_i, input logic [DATA_W-1:0] b_i,
                                   input logic cin_i, input logic sub_i);
        res_t              r;
        logic [DATA_W:0]   t;
        logic [DATA_W-1:0] be;
        be     = sub_i ? ~b_i : b_i;
        t      = {1'b0, a_i} + {1'b0, be} + {{DATA_W{1'b0}}, (sub_i ? 1'b1 : cin_i)};
        r.sum  = t[DATA_W-1:0];
        r.cout = t[DATA_W];
        r.ovf  = (a_i[DATA_W-1] == be[DATA_W-1]) && (t[DATA_W-1] != a_i[DATA_W-1]);
        return r;
    endfunction

    // Results are compared on the falling edge just before the handshake edge consumes them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", sum, mon_e.sum);
                check("cout", {63'd0, cout}, {63'd0, mon_e.cout});
                check("ovf", {63'd0, ovf}, {63'd0, mon_e.ovf});
            end
        end
    end

    // Called at posedge+#1; returns the cycle count of the accept edge.
    task automatic send(input logic [DATA_W-1:0] a_i, input logic [DATA_W-1:0] b_i,
                        input logic cin_i, input logic sub_i, input res_t exp_r,
                        output int acc_cyc);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        acc_cyc = -1;
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            a        = a_i;
            b        = b_i;
            cin      = cin_i;
            sub      = sub_i;
            in_valid = 1'b1;
            exp_q.push_back(exp_r);
            @(posedge clk); #1;
            acc_cyc  = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid(output int v_cyc);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        v_cyc = cyc;
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    // Full directed op: accept, latency check, let the result handshake complete.
    task automatic run_op(input string tag, input logic [DATA_W-1:0] a_i,
                          input logic [DATA_W-1:0] b_i, input logic cin_i,
                          input logic sub_i, input res_t exp_r);
        int acc;
        int v;
        send(a_i, b_i, cin_i, sub_i, exp_r, acc);
        check({tag, "_busy"}, {63'd0, busy}, 1);
        check({tag, "_in_ready_low"}, {63'd0, in_ready}, 0);
        wait_valid(v);
        check({tag, "_latency"}, DATA_W'(v - acc), DATA_W'(LAT));
        @(posedge clk); #1;
        check({tag, "_in_ready_after"}, {63'd0, in_ready}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        int   prev_acc;
        int   v;
        logic [DATA_W-1:0] held;
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;
        logic rc;
        logic rs;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", {63'd0, in_ready}, 1);
        check("rst_out_valid", {63'd0, out_valid}, 0);
        check("rst_busy", {63'd0, busy}, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", {63'd0, cout}, 0);
        check("rst_ovf", {63'd0, ovf}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1_add", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, '{64'd0, 1'b1, 1'b0});
        run_op("t2_sub", 64'd5, 64'd7, 1'b0, 1'b1, '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        run_op("t3_ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               '{64'h8000_0000_0000_0000, 1'b0, 1'b1});
        run_op("t3_ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
               '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});
        run_op("t4_chain", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0,
               '{64'h0001_0000_0000_0001, 1'b0, 1'b0});
        // cin must be ignored on subtraction
        run_op("sub_cin", 64'd100, 64'd1, 1'b1, 1'b1, '{64'd99, 1'b1, 1'b0});

        // T5: backpressure with garbage inputs offered while DONE
        out_ready = 1'b0;
        send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
             '{64'h1234_5678_9ABC_DF00, 1'b0, 1'b0}, acc);
        wait_valid(v);
        held = sum;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            @(posedge clk); #1;
            check("t5_valid_held", {63'd0, out_valid}, 1);
            check("t5_sum_stable", sum, held);
            check("t5_in_ready_low", {63'd0, in_ready}, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_in_ready_after", {63'd0, in_ready}, 1);
        check("t5_valid_dropped", {63'd0, out_valid}, 0);

        // T6: reset after two chunks have been written
        send(64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b0,
             model(64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b0), acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_in_ready", {63'd0, in_ready}, 1);
        check("t6_out_valid", {63'd0, out_valid}, 0);
        check("t6_busy", {63'd0, busy}, 0);
        check("t6_sum", sum, 0);
        check("t6_cout", {63'd0, cout}, 0);
        check("t6_ovf", {63'd0, ovf}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("t6_no_valid", {63'd0, out_valid}, 0);
        end
        run_op("t6_after", 64'h0000_0001_0000_FFFF, 64'h0000_0002_0000_0001, 1'b0, 1'b0,
               '{64'h0000_0003_0001_0000, 1'b0, 1'b0});

        // Back-to-back ops with out_ready held high: fixed accept spacing
        prev_acc = -1;
        for (int i = 0; i < 5; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0), acc);
            if (prev_acc >= 0) check("b2b_period", DATA_W'(acc - prev_acc), DATA_W'(PERIOD));
            prev_acc = acc;
        end

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs), acc);
        end

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("queue_drained", DATA_W'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
